// File: rtl/step_trigger.sv
// Step-pattern gate trigger: per-voice 8-step pattern, fixed-length gate on step advance; trig rises 1 cycle after tick changes, no backpressure.
// Optional accent pattern plane and accent output enabled by STEP_TRIGGER_ACCENT_EN.
module step_trigger #(
    parameter int VOICES   = 4,
    parameter int GATE_LEN = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [2:0]        tick,
    input  logic [7:0]        sel,
    input  logic [VOICES-1:0] mute,
    input  logic              wr_en,
    input  logic [2:0]        wr_voice,
    input  logic [2:0]        wr_step,
    input  logic              wr_val,
`ifdef STEP_TRIGGER_ACCENT_EN
    input  logic              wr_plane,
    output logic [VOICES-1:0] accent,
`endif
    output logic [VOICES-1:0] trig,
    output logic              sel_err
);

    localparam int VW = (VOICES > 1) ? $clog2(VOICES) : 1;

    logic [7:0]        pat [VOICES];
    logic [7:0]        cnt [VOICES];
    logic [2:0]        tick_q;
    logic              primed;
    logic              step_evt;
    logic              wr_ok;
    logic              wr_trig;
    logic [VW-1:0]     wr_idx;
    logic [VOICES-1:0] load;

    assign step_evt = primed && (tick != tick_q);
    assign wr_ok    = wr_en && ({5'd0, wr_voice} < 8'(VOICES));
    assign wr_idx   = wr_voice[VW-1:0];

`ifdef STEP_TRIGGER_ACCENT_EN
    assign wr_trig  = wr_ok && !wr_plane;
`else
    assign wr_trig  = wr_ok;
`endif

    // Pattern read here sees the pre-write value, so a same-cycle write never affects this event.
    always_comb begin
        load = '0;
        for (int v = 0; v < VOICES; v++) begin
            load[v] = step_evt && pat[v][tick] && !mute[v];
        end
    end

    always_comb begin
        trig = '0;
        for (int v = 0; v < VOICES; v++) begin
            trig[v] = (cnt[v] != 8'd0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int v = 0; v < VOICES; v++) begin
                pat[v] <= 8'd0;
                cnt[v] <= 8'd0;
            end
            tick_q  <= 3'd0;
            primed  <= 1'b0;
            sel_err <= 1'b0;
        end else begin
            tick_q <= tick;
            primed <= 1'b1;
            if (primed && (sel != (8'b1 << tick))) begin
                sel_err <= 1'b1;
            end
            for (int v = 0; v < VOICES; v++) begin
                if (load[v]) begin
                    cnt[v] <= 8'(GATE_LEN);
                end else if (cnt[v] != 8'd0) begin
                    cnt[v] <= cnt[v] - 8'd1;
                end
            end
            if (wr_trig) begin
                pat[wr_idx][wr_step] <= wr_val;
            end
        end
    end

`ifdef STEP_TRIGGER_ACCENT_EN
    logic [7:0] acc_pat [VOICES];

    // Accent follows its gate: captured on load, dropped on the cycle the gate runs out.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int v = 0; v < VOICES; v++) begin
                acc_pat[v] <= 8'd0;
            end
            accent <= '0;
        end else begin
            for (int v = 0; v < VOICES; v++) begin
                if (load[v]) begin
                    accent[v] <= acc_pat[v][tick];
                end else if (cnt[v] <= 8'd1) begin
                    accent[v] <= 1'b0;
                end
            end
            if (wr_ok && wr_plane) begin
                acc_pat[wr_idx][wr_step] <= wr_val;
            end
        end
    end
`endif

endmodule

// File: tb/tb_step_trigger.sv
// Bench for step_trigger: directed scenarios plus random traffic against a gate-expiry reference model.
module tb_step_trigger;
    localparam int VOICES   = 4;
    localparam int GATE_LEN = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic [2:0]        tick;
    logic [7:0]        sel;
    logic [VOICES-1:0] mute;
    logic              wr_en;
    logic [2:0]        wr_voice;
    logic [2:0]        wr_step;
    logic              wr_val;
    logic [VOICES-1:0] trig;
    logic              sel_err;
`ifdef STEP_TRIGGER_ACCENT_EN
    logic              wr_plane = 1'b0;
    logic [VOICES-1:0] accent;
`endif

    int checks   = 0;
    int failures = 0;

    // Reference model: pattern bits, absolute gate end time per voice, previous tick.
    int n = 0;
    bit m_pat [8][8];
    int m_end [8];
    int m_prev;
    bit m_primed;
    bit m_serr;

    step_trigger #(.VOICES(VOICES), .GATE_LEN(GATE_LEN)) dut (
        .clk(clk), .rst(rst), .tick(tick), .sel(sel), .mute(mute),
        .wr_en(wr_en), .wr_voice(wr_voice), .wr_step(wr_step), .wr_val(wr_val),
`ifdef STEP_TRIGGER_ACCENT_EN
        .wr_plane(wr_plane), .accent(accent),
`endif
        .trig(trig), .sel_err(sel_err)
    );

    always #5 clk = ~clk;

    function automatic logic [VOICES-1:0] exp_trig();
        logic [VOICES-1:0] r;
        for (int v = 0; v < VOICES; v++) r[v] = (n < m_end[v]);
        return r;
    endfunction

    // One clock edge: update the model from the inputs seen at the edge, then step past it.
    task automatic cyc();
        @(posedge clk);
        n++;
        if (rst) begin
            for (int v = 0; v < 8; v++) begin
                m_end[v] = 0;
                for (int s = 0; s < 8; s++) m_pat[v][s] = 1'b0;
            end
            m_prev = 0; m_primed = 1'b0; m_serr = 1'b0;
        end else begin
            if (m_primed && int'(tick) != m_prev) begin
                for (int v = 0; v < VOICES; v++)
                    if (m_pat[v][tick] && !mute[v]) m_end[v] = n + GATE_LEN;
            end
            if (m_primed && sel != (8'd1 << tick)) m_serr = 1'b1;
            if (wr_en && int'(wr_voice) < VOICES) m_pat[wr_voice][wr_step] = wr_val;
            m_prev = int'(tick);
            m_primed = 1'b1;
        end
        #1;
    endtask

    task automatic set_tick(input int t);
        tick = 3'(t);
        sel  = 8'd1 << t;
    endtask

    task automatic write_bit(input int v, input int s, input bit val);
        wr_en = 1'b1; wr_voice = 3'(v); wr_step = 3'(s); wr_val = val;
        cyc();
        wr_en = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        mute = '0; wr_en = 1'b0; wr_voice = '0; wr_step = '0; wr_val = 1'b0;
        set_tick(3);
        do_reset();
        checks++;
        if (trig !== '0 || sel_err !== 1'b0) begin
            failures++;
            $display("FAIL reset_state trig=%b sel_err=%b required trig=0 sel_err=0", trig, sel_err);
        end
        for (int i = 0; i < 30; i++) begin
            cyc();
            checks++;
            if (trig !== '0 || sel_err !== 1'b0) begin
                failures++;
                $display("FAIL idle_tick3 cycle=%0d trig=%b sel_err=%b required 0/0", i, trig, sel_err);
            end
        end
    endtask

    task automatic step_and_count(input int t, input int want, input string name);
        int hi = 0;
        set_tick(t);
        for (int i = 0; i < 40; i++) begin
            cyc();
            if (i == 0 && want > 0) begin
                checks++;
                if (trig[0] !== 1'b1) begin
                    failures++;
                    $display("FAIL %s_rise trig0=%b required 1", name, trig[0]);
                end
            end
            checks++;
            if (trig !== exp_trig()) begin
                failures++;
                $display("FAIL %s_model cycle=%0d trig=%b required %b", name, i, trig, exp_trig());
            end
            if (trig[0]) hi++;
        end
        checks++;
        if (hi != want) begin
            failures++;
            $display("FAIL %s_len trig0_high=%0d required %0d", name, hi, want);
        end
    endtask

    task automatic test_pattern_steps();
        for (int s = 0; s < 8; s++) write_bit(0, s, (s == 0 || s == 2));
        step_and_count(0, GATE_LEN, "step0");
        step_and_count(1, 0, "step1");
        step_and_count(2, GATE_LEN, "step2");
    endtask

    task automatic test_mute();
        int hi = 0;
        set_tick(0);
        for (int i = 0; i < 40; i++) begin
            if (i == 5) mute[0] = 1'b1;
            cyc();
            if (trig[0]) hi++;
        end
        checks++;
        if (hi != GATE_LEN) begin
            failures++;
            $display("FAIL mute_active_gate trig0_high=%0d required %0d", hi, GATE_LEN);
        end
        step_and_count(1, 0, "mute_step1");
        step_and_count(2, 0, "mute_step2");
        mute = '0;
    endtask

    task automatic test_retrigger();
        int t = 2;
        for (int s = 0; s < 8; s++) write_bit(1, s, 1'b1);
        for (int i = 0; i < 40; i++) begin
            t = (t + 1) % 8;
            set_tick(t);
            cyc();
            checks++;
            if (trig[1] !== 1'b1) begin
                failures++;
                $display("FAIL retrigger cycle=%0d trig1=%b required 1", i, trig[1]);
            end
        end
        for (int i = 0; i < 20; i++) cyc();
        checks++;
        if (trig !== exp_trig()) begin
            failures++;
            $display("FAIL retrigger_drain trig=%b required %b", trig, exp_trig());
        end
    endtask

    task automatic test_sel_err();
        checks++;
        if (sel_err !== 1'b0) begin
            failures++;
            $display("FAIL sel_err_pre sel_err=%b required 0", sel_err);
        end
        tick = 3'd5; sel = 8'b0000_0001;
        cyc();
        checks++;
        if (sel_err !== 1'b1) begin
            failures++;
            $display("FAIL sel_err_set sel_err=%b required 1", sel_err);
        end
        set_tick(5);
        for (int i = 0; i < 10; i++) begin
            cyc();
            checks++;
            if (sel_err !== 1'b1) begin
                failures++;
                $display("FAIL sel_err_sticky cycle=%0d sel_err=%b required 1", i, sel_err);
            end
        end
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        checks++;
        if (sel_err !== 1'b0) begin
            failures++;
            $display("FAIL sel_err_clear sel_err=%b required 0", sel_err);
        end
    endtask

    task automatic test_rbw_and_reset();
        set_tick(3);
        do_reset();
        cyc();
        set_tick(4);
        write_bit(2, 4, 1'b1);
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (trig[2] !== 1'b0) begin
                failures++;
                $display("FAIL rbw_old_value cycle=%0d trig2=%b required 0", i, trig[2]);
            end
            cyc();
        end
        for (int t = 5; t < 12; t++) begin
            set_tick(t % 8);
            cyc();
        end
        set_tick(4);
        cyc();
        checks++;
        if (trig[2] !== 1'b1) begin
            failures++;
            $display("FAIL rbw_next_visit trig2=%b required 1", trig[2]);
        end
        cyc(); cyc(); cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        checks++;
        if (trig !== '0) begin
            failures++;
            $display("FAIL reset_mid_gate trig=%b required 0", trig);
        end
        set_tick(3);
        cyc(); cyc();
        set_tick(4);
        cyc();
        checks++;
        if (trig !== '0) begin
            failures++;
            $display("FAIL pattern_lost trig=%b required 0", trig);
        end
    endtask

    task automatic test_random();
        int t = 4;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(2, 0) == 0) t = int'($urandom_range(7, 0));
            set_tick(t);
            if ($urandom_range(60, 0) == 0) sel = 8'($urandom);
            mute     = VOICES'($urandom);
            wr_en    = ($urandom_range(1, 0) == 1);
            wr_voice = 3'($urandom);
            wr_step  = 3'($urandom);
            wr_val   = ($urandom_range(3, 0) != 0);
            cyc();
            wr_en = 1'b0;
            checks++;
            if (trig !== exp_trig() || sel_err !== m_serr) begin
                failures++;
                $display("FAIL random cycle=%0d trig=%b sel_err=%b required %b/%b",
                         i, trig, sel_err, exp_trig(), m_serr);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        test_reset();
        test_pattern_steps();
        test_mute();
        test_retrigger();
        test_sel_err();
        test_rbw_and_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
